// File: rtl/fc1_input_loader.sv
// fc1_input_loader: assembles a binarized image frame for the fc1 layer.
//
// Rows arrive one beat at a time. Each pixel is thresholded to one bit and
// stored in a shadow register. When the final row of a well-formed frame is
// accepted, the whole frame is copied to g_input in one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   row beat valid
//   in_ready   row beat accepted when in_valid && in_ready
//   in_row     COLS pixels, pixel c at in_row[c*PW +: PW]
//   in_last    beat is the final row of its frame
//   out_valid  g_input holds a complete frame
//   out_ready  consumer has sampled g_input
//   g_input    binarized frame, bit r*COLS+c
//   err        one-cycle framing-error pulse (short or long frame)
//   frame_cnt  count of delivered frames, wrapping
module fc1_input_loader #(
  parameter int unsigned ROWS          = 9,
  parameter int unsigned COLS          = 9,
  parameter int unsigned PW            = 8,
  parameter int unsigned BIN_THRESHOLD = 128,
  parameter int unsigned ISIZE         = ROWS * COLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COLS*PW-1:0] in_row,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ISIZE-1:0]   g_input,
  output logic               err,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned     RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } out_state_e;

  out_state_e       state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [ISIZE-1:0] shadow_q, shadow_d;
  logic [ISIZE-1:0] g_q, g_d;
  logic             err_q, err_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic [COLS-1:0]  bits;
  logic             at_last;
  logic             accept;
  int unsigned      base;

  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      bits[c] = (32'(in_row[c*PW +: PW]) >= BIN_THRESHOLD);
    end
  end

  assign at_last = (row_q == LAST_ROW);
  // Only the final row is held off by an unconsumed frame; earlier rows can
  // fill the shadow while the previous frame is still on g_input.
  assign in_ready  = rst && !(at_last && (state_q == HELD) && !out_ready);
  assign accept    = in_valid && in_ready;
  assign base      = 32'(row_q) * COLS;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    shadow_d = shadow_q;
    g_d      = g_q;
    err_d    = 1'b0;
    fcnt_d   = fcnt_q;

    if ((state_q == HELD) && out_ready) begin
      state_d = EMPTY;
    end

    if (accept) begin
      shadow_d[base +: COLS] = bits;
      unique case ({at_last, in_last})
        2'b00: row_d = row_q + 1'b1;
        2'b11: begin
          // shadow_d already contains the final row, so the copy is complete.
          // A coincident consume is overridden: the new frame follows with no gap.
          g_d     = shadow_d;
          state_d = HELD;
          fcnt_d  = fcnt_q + 16'd1;
          row_d   = '0;
        end
        default: begin
          err_d = 1'b1;
          row_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      row_q    <= '0;
      shadow_q <= '0;
      g_q      <= '0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
      g_q      <= g_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign out_valid = (state_q == HELD);
  assign g_input   = g_q;
  assign err       = err_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_fc1_input_loader.sv
module tb_fc1_input_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_row;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [80:0] g_input;
  logic        err;
  logic [15:0] frame_cnt;

  // Small second instance used only to reach the frame counter wrap quickly.
  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_in_row;
  logic        w_in_last;
  logic        w_out_valid;
  logic [1:0]  w_g_input;
  logic        w_err;
  logic [15:0] w_frame_cnt;

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  fc1_input_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .g_input(g_input), .err(err), .frame_cnt(frame_cnt)
  );

  fc1_input_loader #(.ROWS(1), .COLS(2), .PW(8), .BIN_THRESHOLD(128)) wdut (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_row(w_in_row), .in_last(w_in_last), .out_valid(w_out_valid),
    .out_ready(1'b1), .g_input(w_g_input), .err(w_err), .frame_cnt(w_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       bit_exp;
  } thr_vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // mode 0: every pixel = v; mode 1: 200 at even c, 50 at odd c;
  // mode 2: 200 where r+c even, 50 otherwise.
  function automatic logic [71:0] mkrow(input int mode, input int r, input logic [7:0] v);
    logic [71:0] row;
    row = '0;
    for (int c = 0; c < 9; c++) begin
      case (mode)
        0:       row[c*8 +: 8] = v;
        1:       row[c*8 +: 8] = (c % 2 == 0) ? 8'd200 : 8'd50;
        default: row[c*8 +: 8] = ((r + c) % 2 == 0) ? 8'd200 : 8'd50;
      endcase
    end
    return row;
  endfunction

  function automatic logic [80:0] mkexp(input int mode, input logic b);
    logic [80:0] g;
    g = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        case (mode)
          0:       g[r*9 + c] = b;
          1:       g[r*9 + c] = (c % 2 == 0);
          default: g[r*9 + c] = ((r + c) % 2 == 0);
        endcase
    return g;
  endfunction

  task automatic send_beat(input logic [71:0] row, input logic last);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_row = row; in_last = last; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int mode, input logic [7:0] v);
    for (int r = 0; r < 9; r++) send_beat(mkrow(mode, r, v), r == 8);
  endtask

  thr_vec_t tv[6];

  initial begin
    tv[0] = '{8'd0,   1'b0};
    tv[1] = '{8'd127, 1'b0};
    tv[2] = '{8'd128, 1'b1};
    tv[3] = '{8'd255, 1'b1};
    tv[4] = '{8'd50,  1'b0};
    tv[5] = '{8'd200, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_row = '0; in_last = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_row = 16'h807F; w_in_last = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_g_input", 128'(g_input), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("release_in_ready", 128'(in_ready), 128'd1);

    // Basic frame, consumer not ready
    for (int r = 0; r < 8; r++) send_beat(mkrow(1, r, 8'd0), 1'b0);
    chk("basic_pre_valid", 128'(out_valid), 128'd0);
    send_beat(mkrow(1, 8, 8'd0), 1'b1);
    chk("basic_out_valid", 128'(out_valid), 128'd1);
    chk("basic_g_input", 128'(g_input), 128'(mkexp(1, 1'b0)));
    chk("basic_frame_cnt", 128'(frame_cnt), 128'd1);

    // Backpressure: 8 rows accepted while HELD, 9th stalls
    for (int r = 0; r < 8; r++) send_beat(mkrow(0, r, 8'd255), 1'b0);
    @(negedge clk);
    in_row = mkrow(0, 8, 8'd255); in_last = 1'b1; in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    chk("bp_g_stable", 128'(g_input), 128'(mkexp(1, 1'b0)));
    chk("bp_cnt_stable", 128'(frame_cnt), 128'd1);
    @(negedge clk); out_ready = 1'b1; #1;
    chk("bp_in_ready_high", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid_no_gap", 128'(out_valid), 128'd1);
    chk("bp_new_frame", 128'(g_input), 128'(mkexp(0, 1'b1)));
    chk("bp_frame_cnt", 128'(frame_cnt), 128'd2);
    @(posedge clk); #1;
    chk("bp_consumed", 128'(out_valid), 128'd0);

    // Short frame: in_last on row 4
    for (int r = 0; r < 5; r++) send_beat(mkrow(2, r, 8'd0), r == 4);
    chk("short_err", 128'(err), 128'd1);
    chk("short_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    chk("short_err_pulse", 128'(err), 128'd0);
    chk("short_g_kept", 128'(g_input), 128'(mkexp(0, 1'b1)));

    // Long frame: 9 rows without in_last
    for (int r = 0; r < 9; r++) send_beat(mkrow(2, r, 8'd0), 1'b0);
    chk("long_err", 128'(err), 128'd1);
    chk("long_out_valid", 128'(out_valid), 128'd0);
    chk("long_frame_cnt", 128'(frame_cnt), 128'd2);

    // Correct frame after errors
    send_frame(2, 8'd0);
    chk("recover_valid", 128'(out_valid), 128'd1);
    chk("recover_g_input", 128'(g_input), 128'(mkexp(2, 1'b0)));
    chk("recover_frame_cnt", 128'(frame_cnt), 128'd3);
    chk("recover_err", 128'(err), 128'd0);

    // Threshold table
    for (int i = 0; i < 6; i++) begin
      send_frame(0, tv[i].pix);
      chk($sformatf("thr_%0d_g", tv[i].pix), 128'(g_input), 128'(mkexp(0, tv[i].bit_exp)));
      chk($sformatf("thr_%0d_cnt", tv[i].pix), 128'(frame_cnt), 128'(4 + i));
    end

    // Reset mid-frame
    for (int r = 0; r < 5; r++) send_beat(mkrow(0, r, 8'd255), 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_g_input", 128'(g_input), 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    chk("midrst_frame_cnt", 128'(frame_cnt), 128'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst_release_ready", 128'(in_ready), 128'd1);
    send_frame(1, 8'd0);
    chk("midrst_valid", 128'(out_valid), 128'd1);
    chk("midrst_g_fresh", 128'(g_input), 128'(mkexp(1, 1'b0)));
    chk("midrst_frame_cnt1", 128'(frame_cnt), 128'd1);

    // Frame counter wrap on the single-row instance
    @(negedge clk); w_in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", 128'(w_frame_cnt), 128'hFFFF);
    chk("wrap_g_input", 128'(w_g_input), 128'b10);
    @(posedge clk); #1;
    chk("wrap_zero", 128'(w_frame_cnt), 128'h0000);
    chk("wrap_err", 128'(w_err), 128'd0);
    w_in_valid = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/fc1_input_loader.md
FC1_INPUT_LOADER -- requirements
Module: fc1_input_loader

Interface
REQ-001 SHALL have parameter ROWS, default 9: image rows per frame.
REQ-002 SHALL have parameter COLS, default 9: pixels per row.
REQ-003 SHALL have parameter PW, default 8: pixel width, unsigned.
REQ-004 SHALL have parameter BIN_THRESHOLD, default 128: binarization threshold.
REQ-005 SHALL have parameter ISIZE, default ROWS*COLS (81): width of the output vector and the fc1 input width.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1: row beat valid.
REQ-009 SHALL have port in_ready, output, 1: row beat accepted when in_valid && in_ready.
REQ-010 SHALL have port in_row, input, COLS*PW: pixel c at in_row[c*PW +: PW].
REQ-011 SHALL have port in_last, input, 1: beat is the final row of its frame.
REQ-012 SHALL have port out_valid, output, 1: g_input holds a complete frame.
REQ-013 SHALL have port out_ready, input, 1: consumer has sampled g_input.
REQ-014 SHALL have port g_input, output, ISIZE: binarized frame for fc1.
REQ-015 SHALL have port err, output, 1: one-cycle framing-error pulse.
REQ-016 SHALL have port frame_cnt, output, 16: count of delivered frames, wrapping.

Function
REQ-017 SHALL binarize each pixel as bit = (pixel >= BIN_THRESHOLD), using an unsigned compare.
REQ-018 SHALL write the bit for row r, pixel c to index r*COLS+c of a shadow register; the row counter row_cnt runs from 0 to ROWS-1.
REQ-019 SHALL treat the output as two states: EMPTY (out_valid=0) and HELD (out_valid=1); g_input changes only on a frame transfer.
REQ-020 SHALL drive in_ready = rst && !(row_cnt==ROWS-1 && out_valid && !out_ready), so that non-final rows are accepted while in HELD.
REQ-021 SHALL, on acceptance with row_cnt<ROWS-1 and in_last=0, store the row and increment row_cnt.
REQ-022 SHALL, on acceptance with row_cnt==ROWS-1 and in_last=1, load g_input from the shadow including this row, set out_valid=1 on the next cycle, increment frame_cnt, and set row_cnt=0.
REQ-023 SHALL give a latency of 1 cycle from acceptance of the final row to out_valid and new g_input.
REQ-024 SHALL, on acceptance with in_last=1 and row_cnt<ROWS-1 (short frame), pulse err for 1 cycle, discard the frame, set row_cnt=0, and leave g_input, out_valid and frame_cnt unchanged.
REQ-025 SHALL, on acceptance with row_cnt==ROWS-1 and in_last=0 (long frame), pulse err, discard the frame and set row_cnt=0; the next beat starts a new frame.
REQ-026 SHALL clear out_valid on the cycle after out_valid && out_ready, unless a frame transfer occurs in the same cycle.
REQ-027 SHALL, when out_ready handshake and frame transfer coincide, keep out_valid=1 and present the new frame with no gap.
REQ-028 SHALL wrap frame_cnt from 0xFFFF to 0x0000.
REQ-029 SHALL ignore in_row and in_last when in_valid=0; in_valid=0 between rows SHALL NOT affect frame assembly.
REQ-030 SHALL keep g_input stable while out_valid=1 and out_ready=0.

Reset
REQ-031 SHALL, while rst=0, asynchronously force out_valid=0, g_input=0, err=0, frame_cnt=0, row_cnt=0, shadow=0 and in_ready=0.
REQ-032 SHALL, on reset assertion mid-frame, discard the partial frame; the first beat accepted after release is row 0.
REQ-033 SHALL release reset synchronously to clk; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-034 SHALL cover basic frame: 9 beats, row r pixels = 8'd200 at even c and 8'd50 at odd c, last beat with in_last=1 -> one cycle later out_valid=1, g_input bit r*9+c = ~c[0], frame_cnt=1.
REQ-035 SHALL cover threshold boundary: pixels 127, 128 and 255 -> bits 0, 1, 1.
REQ-036 SHALL cover backpressure: out_ready=0 after a frame, next frame sends 8 rows then holds the 9th with in_valid=1 -> in_ready=0 and g_input unchanged; raising out_ready transfers the new frame in the same cycle and out_valid stays 1.
REQ-037 SHALL cover framing errors: in_last=1 on row 4 -> err pulses once and out_valid stays 0; 9 rows with in_last=0 -> err pulses; a following correct frame is delivered intact.
REQ-038 SHALL cover reset mid-frame: rst=0 after 5 rows -> all outputs 0; after release a full 9-row frame yields out_valid=1 and frame_cnt=1.
REQ-039 SHALL cover wrap: frame_cnt preloaded by 65536 deliveries -> frame_cnt reads 0x0000.
